// File: rtl/clk_rst_pkg.sv
// Shared state encodings and width limits for the clock/reset sequencer.
// Latency: n/a. Backpressure: n/a.
`timescale 1ns/1ps
package clk_rst_pkg;

  localparam int MAX_RST     = 8;
  localparam int RST_IDX_W   = $clog2(MAX_RST);
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLDOFF   = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sync_bits.sv
// Per-bit multi-flop synchroniser for independent quasi-static async inputs.
// Latency: STAGES bus_clk cycles. Backpressure: none.
`timescale 1ns/1ps
module sync_bits #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             bus_clk,
  input  logic             reset_global,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// Waits for PLL locks, holds off, then releases domain resets in ascending order.
// Latency: 3 + (holdoff_cfg+1) + (NUM_RST-1)*(stagger_cfg+1) + 1 cycles to RUN. Backpressure: none.
`timescale 1ns/1ps
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int NUM_RST   = 3,
  parameter int NUM_LOCKS = 1,
  parameter int HOLDOFF_W = 16,
  parameter int STAGGER_W = 8
) (
  input  logic                 bus_clk,
  input  logic                 reset_global,
  input  logic [NUM_LOCKS-1:0] locked,
  input  logic [NUM_LOCKS-1:0] lock_mask,
  input  logic [HOLDOFF_W-1:0] holdoff_cfg,
  input  logic [STAGGER_W-1:0] stagger_cfg,
  input  logic                 sw_rst_req,
  input  logic                 lock_lost_clr,
  output logic [NUM_RST-1:0]   rst_out,
  output logic                 clocks_ready,
  output logic                 lock_lost,
  output logic [1:0]           state
);

  localparam logic [RST_IDX_W-1:0] LAST_IDX = RST_IDX_W'(NUM_RST - 1);

  logic [NUM_LOCKS-1:0] locked_sync;
  logic                 all_locked;
  logic                 lock_drop;
  seq_state_t           cur_st;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic [STAGGER_W-1:0] stag_cnt;
  logic [RST_IDX_W-1:0] rel_idx;

  sync_bits #(
    .WIDTH  (NUM_LOCKS),
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .bus_clk      (bus_clk),
    .reset_global (reset_global),
    .din          (locked),
    .dout         (locked_sync)
  );

  assign all_locked = &(locked_sync | lock_mask);
  assign lock_drop  = (cur_st != ST_WAIT_LOCK) && !all_locked;

  // Counters compare before incrementing, so an all-ones config never wraps.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      cur_st       <= ST_WAIT_LOCK;
      rst_out      <= '1;
      clocks_ready <= 1'b0;
      lock_lost    <= 1'b0;
      hold_cnt     <= '0;
      stag_cnt     <= '0;
      rel_idx      <= '0;
    end else begin
      if (lock_drop)          lock_lost <= 1'b1;
      else if (lock_lost_clr) lock_lost <= 1'b0;

      if (lock_drop) begin
        cur_st       <= ST_WAIT_LOCK;
        rst_out      <= '1;
        clocks_ready <= 1'b0;
      end else if (sw_rst_req && cur_st != ST_WAIT_LOCK) begin
        cur_st       <= ST_HOLDOFF;
        hold_cnt     <= '0;
        rst_out      <= '1;
        clocks_ready <= 1'b0;
      end else begin
        case (cur_st)
          ST_WAIT_LOCK: begin
            if (all_locked) begin
              cur_st   <= ST_HOLDOFF;
              hold_cnt <= '0;
            end
          end
          ST_HOLDOFF: begin
            // rst_out is all ones here; shifting in a zero releases bit 0 first.
            if (hold_cnt == holdoff_cfg) begin
              cur_st   <= ST_RELEASE;
              rel_idx  <= '0;
              stag_cnt <= '0;
              rst_out  <= rst_out << 1;
            end else begin
              hold_cnt <= hold_cnt + HOLDOFF_W'(1);
            end
          end
          ST_RELEASE: begin
            if (rel_idx == LAST_IDX) begin
              cur_st       <= ST_RUN;
              clocks_ready <= 1'b1;
            end else if (stag_cnt == stagger_cfg) begin
              rel_idx  <= rel_idx + RST_IDX_W'(1);
              stag_cnt <= '0;
              rst_out  <= rst_out << 1;
            end else begin
              stag_cnt <= stag_cnt + STAGGER_W'(1);
            end
          end
          ST_RUN: begin
            rst_out      <= '0;
            clocks_ready <= 1'b1;
          end
          default: cur_st <= ST_WAIT_LOCK;
        endcase
      end
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench: expected output transitions (value and cycle) queued as stimulus is applied.
// Latency: n/a. Backpressure: n/a.
`timescale 1ns/1ps
module tb_clk_rst_sequencer;

  localparam int N  = 3;
  localparam int HW = 4;
  localparam int SW = 3;
  localparam logic [6:0] RST_TUP = 7'b000_0111;

  logic          bus_clk = 1'b0;
  logic          reset_global = 1'b0;
  logic [0:0]    locked;
  logic [0:0]    lock_mask;
  logic [HW-1:0] holdoff_cfg;
  logic [SW-1:0] stagger_cfg;
  logic          sw_rst_req;
  logic          lock_lost_clr;
  logic [N-1:0]  rst_out;
  logic          clocks_ready;
  logic          lock_lost;
  logic [1:0]    state;

  typedef struct {
    int         cyc;
    logic [6:0] val;
    string      tag;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         hcfg;
  int         scfg;
  int         base;
  int         t;
  logic [6:0] obs;
  logic [6:0] prev = RST_TUP;

  clk_rst_sequencer #(
    .NUM_RST   (N),
    .NUM_LOCKS (1),
    .HOLDOFF_W (HW),
    .STAGGER_W (SW)
  ) dut (
    .bus_clk       (bus_clk),
    .reset_global  (reset_global),
    .locked        (locked),
    .lock_mask     (lock_mask),
    .holdoff_cfg   (holdoff_cfg),
    .stagger_cfg   (stagger_cfg),
    .sw_rst_req    (sw_rst_req),
    .lock_lost_clr (lock_lost_clr),
    .rst_out       (rst_out),
    .clocks_ready  (clocks_ready),
    .lock_lost     (lock_lost),
    .state         (state)
  );

  always #5 bus_clk = ~bus_clk;
  always @(posedge bus_clk) cyc <= cyc + 1;

  assign obs = {lock_lost, state, clocks_ready, rst_out};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] tup(input logic ll, input logic [1:0] st,
                                     input logic rdy, input logic [2:0] r);
    return {ll, st, rdy, r};
  endfunction

  task automatic push(input int c, input logic [6:0] v, input string tag);
    ev_t e;
    e.cyc = c;
    e.val = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Full sequence from the edge that enters HOLDOFF: 111 -> 110 -> 100 -> 000, then RUN.
  task automatic expect_seq(input int th, input logic ll);
    logic [2:0] r;
    int         te;
    r  = 3'b111;
    push(th, tup(ll, 2'd1, 1'b0, r), "hold");
    te = th + hcfg + 1;
    for (int k = 0; k < N; k++) begin
      r = {r[1:0], 1'b0};
      push(te, tup(ll, 2'd2, 1'b0, r), "rel");
      if (k < N - 1) te = te + scfg + 1;
    end
    push(te + 1, tup(ll, 2'd3, 1'b1, 3'b000), "run");
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge bus_clk);
      #1;
    end
    check("drain", exp_q.size(), 0);
    repeat (4) begin
      @(negedge bus_clk);
      #1;
    end
  endtask

  always @(negedge bus_clk) begin
    ev_t e;
    if (reset_global) begin
      prev <= RST_TUP;
    end else if (obs !== prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected", obs, prev);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_val"}, obs, e.val);
        check({e.tag, "_cyc"}, cyc, e.cyc);
      end
      prev <= obs;
    end
  end

  initial begin
    locked        = 1'b1;
    lock_mask     = 1'b0;
    holdoff_cfg   = 4'd4;
    stagger_cfg   = 3'd1;
    hcfg          = 4;
    scfg          = 1;
    sw_rst_req    = 1'b0;
    lock_lost_clr = 1'b0;

    #1 reset_global = 1'b1;
    #1 check("rst_init", obs, RST_TUP);
    repeat (3) @(negedge bus_clk);
    reset_global = 1'b0;
    base = cyc;
    expect_seq(base + 3, 1'b0);
    drain(60);

    // One-cycle lock glitch in RUN.
    @(negedge bus_clk);
    t = cyc;
    locked = 1'b0;
    push(t + 3, tup(1'b1, 2'd0, 1'b0, 3'b111), "loss");
    expect_seq(t + 4, 1'b1);
    @(negedge bus_clk);
    locked = 1'b1;
    drain(60);

    // Lock loss with a clear in the same cycle: set wins.
    @(negedge bus_clk);
    t = cyc;
    locked = 1'b0;
    push(t + 3, tup(1'b1, 2'd0, 1'b0, 3'b111), "loss_clr");
    expect_seq(t + 4, 1'b1);
    @(negedge bus_clk);
    locked = 1'b1;
    @(negedge bus_clk);
    lock_lost_clr = 1'b1;
    @(negedge bus_clk);
    lock_lost_clr = 1'b0;
    drain(60);

    // Clear on its own.
    @(negedge bus_clk);
    t = cyc;
    lock_lost_clr = 1'b1;
    push(t + 1, tup(1'b0, 2'd3, 1'b1, 3'b000), "clr");
    @(negedge bus_clk);
    lock_lost_clr = 1'b0;
    drain(20);

    // Software reset in RUN, then again mid-RELEASE at 110.
    @(negedge bus_clk);
    t = cyc;
    sw_rst_req = 1'b1;
    push(t + 1, tup(1'b0, 2'd1, 1'b0, 3'b111), "sw_hold");
    push(t + 6, tup(1'b0, 2'd2, 1'b0, 3'b110), "sw_rel");
    expect_seq(t + 7, 1'b0);
    @(negedge bus_clk);
    sw_rst_req = 1'b0;
    while (cyc < t + 6) @(negedge bus_clk);
    sw_rst_req = 1'b1;
    @(negedge bus_clk);
    sw_rst_req = 1'b0;
    drain(60);

    // Asynchronous reset between clock edges, then masked lock.
    @(posedge bus_clk);
    #3 reset_global = 1'b1;
    #1 check("async_rst", obs, RST_TUP);
    locked    = 1'b0;
    lock_mask = 1'b1;
    repeat (2) @(negedge bus_clk);
    reset_global = 1'b0;
    base = cyc;
    expect_seq(base + 1, 1'b0);
    drain(60);

    // Unmasking a dead lock drops to WAIT_LOCK; sw_rst_req there is ignored.
    @(negedge bus_clk);
    t = cyc;
    lock_mask = 1'b0;
    push(t + 1, tup(1'b1, 2'd0, 1'b0, 3'b111), "mask_loss");
    @(negedge bus_clk);
    @(negedge bus_clk);
    sw_rst_req = 1'b1;
    @(negedge bus_clk);
    sw_rst_req = 1'b0;
    drain(20);
    @(negedge bus_clk);
    t = cyc;
    locked = 1'b1;
    expect_seq(t + 3, 1'b1);
    drain(60);

    // Maximum hold-off (16 cycles) with back-to-back releases.
    @(posedge bus_clk);
    #3 reset_global = 1'b1;
    holdoff_cfg = 4'hF;
    stagger_cfg = 3'd0;
    hcfg        = 15;
    scfg        = 0;
    #1 check("async_rst2", obs, RST_TUP);
    repeat (2) @(negedge bus_clk);
    reset_global = 1'b0;
    base = cyc;
    expect_seq(base + 3, 1'b0);
    drain(80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_rst_sequencer.md
CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

Interface
REQ-001 Parameter NUM_RST, default 3, number of sequenced reset outputs (1..8).
REQ-002 Parameter NUM_LOCKS, default 1, number of PLL/MMCM lock inputs (1..4).
REQ-003 Parameter HOLDOFF_W, default 16, width of hold-off counter and config.
REQ-004 Parameter STAGGER_W, default 8, width of inter-release stagger counter and config.
REQ-005 Port bus_clk, input, 1, sequencer clock.
REQ-006 Port reset_global, input, 1, asynchronous active-high reset.
REQ-007 Port locked, input, NUM_LOCKS, asynchronous lock indicators, active-high.
REQ-008 Port lock_mask, input, NUM_LOCKS, 1 = lock bit ignored; quasi-static.
REQ-009 Port holdoff_cfg, input, HOLDOFF_W, hold-off length minus one; quasi-static.
REQ-010 Port stagger_cfg, input, STAGGER_W, gap between successive releases minus one; quasi-static.
REQ-011 Port sw_rst_req, input, 1, single-cycle request to re-run sequence.
REQ-012 Port lock_lost_clr, input, 1, single-cycle clear of sticky flag.
REQ-013 Port rst_out, output, NUM_RST, active-high domain resets, bit 0 released first.
REQ-014 Port clocks_ready, output, 1, high only in RUN.
REQ-015 Port lock_lost, output, 1, sticky lock-loss flag.
REQ-016 Port state, output, 2, current FSM state encoding.

Function
REQ-017 locked SHALL pass a 2-flop synchroniser per bit; all_locked = AND over (locked_sync | lock_mask).
REQ-018 FSM states: WAIT_LOCK=0, HOLDOFF=1, RELEASE=2, RUN=3.
REQ-019 WAIT_LOCK: all rst_out high; on all_locked go HOLDOFF, loading hold-off counter with 0.
REQ-020 HOLDOFF SHALL last exactly holdoff_cfg+1 cycles, then go RELEASE with release index 0 and stagger counter 0.
REQ-021 RELEASE: rst_out[idx] deasserts on entry and then every stagger_cfg+1 cycles in ascending index; once rst_out[NUM_RST-1] deasserts, go RUN next cycle.
REQ-022 Released bits SHALL stay low while in RELEASE/RUN; unreleased bits stay high.
REQ-023 RUN: clocks_ready high, all rst_out low.
REQ-024 all_locked low in HOLDOFF, RELEASE or RUN SHALL force all rst_out high and clocks_ready low on the next edge, set lock_lost, and go WAIT_LOCK.
REQ-025 sw_rst_req in HOLDOFF, RELEASE or RUN with all_locked high SHALL assert all rst_out next edge and restart HOLDOFF from count 0; lock_lost unaffected.
REQ-026 sw_rst_req in WAIT_LOCK SHALL be ignored.
REQ-027 Lock loss and sw_rst_req in same cycle: lock loss wins.
REQ-028 lock_lost_clr clears flag; simultaneous set and clear: set wins.
REQ-029 All outputs SHALL be registered; no combinational path input-to-output.
REQ-030 Counters SHALL not wrap; holdoff_cfg all-ones gives 2^HOLDOFF_W cycles.
REQ-031 With locks already synced high, latency from reset_global deassertion to clocks_ready = 3 + (holdoff_cfg+1) + (NUM_RST-1)*(stagger_cfg+1) + 1 cycles.

Reset
REQ-032 On reset_global: state WAIT_LOCK, rst_out all ones, clocks_ready 0, lock_lost 0, counters and synchronisers 0.
REQ-033 Reset assertion SHALL take effect asynchronously; deassertion processed on next bus_clk edge.

Structure
REQ-034 State encodings and width limits SHALL live in shared package clk_rst_pkg.
REQ-035 Lock synchroniser SHALL be sub-module sync_bits (NUM_LOCKS wide, 2 stages).
REQ-036 Downstream per-domain reset_sync instances stay outside this block.

Verification
REQ-037 NUM_RST=3, holdoff_cfg=4, stagger_cfg=1, locked=1 from reset -> rst_out 111->110->100->000 at 2-cycle spacing; clocks_ready high at cycle 3+5+4+1=13.
REQ-038 In RUN drop locked for 1 cycle -> rst_out=111 within 4 cycles, lock_lost=1, state=0; relock -> sequence repeats.
REQ-039 lock_mask=1 with locked=0 -> sequence completes as if locked.
REQ-040 sw_rst_req mid-RELEASE (rst_out=110) -> rst_out=111 next cycle, holdoff restarts, full sequence reruns, lock_lost stays 0.
REQ-041 lock_lost_clr and lock loss same cycle -> lock_lost=1; later lock_lost_clr alone -> 0.
REQ-042 reset_global pulse in RUN -> outputs return to reset values without waiting for bus_clk edge.
